matrix_result_writeback: RTL and testbench
==========================================

// Module: matrix_result_writeback
// PURPOSE
// Receiving end of the 3x3 multiplier result stream (c_out/c_valid/row/col/done).
// Captures all M*P results, rescales them from fixed-point, saturates them, and buffers them.
// It then replays the buffer as a writer into a downstream multiplier's A/B load port
// (addr/data/wen), so products chain (e.g. F*P*F') without host intervention.
// PARAMETERS
// M           3    result rows
// P           3    result cols
// DATA_WIDTH  32   signed element width on the load port
// ACC_WIDTH   66   signed result width from the multiplier, (2*DATA_WIDTH)+2
// SHIFT       10   fixed-point rescale, arithmetic right shift
// PORTS
// clk        in   1           rising-edge clock
// rst        in   1           synchronous, active-high reset
// arm        in   1           1-cycle pulse: start a capture (honoured only in IDLE)
// transpose  in   1           sampled with arm; 1 = write C' instead of C
// c_out      in   ACC_WIDTH   signed multiplier result
// c_valid    in   1           c_out/row/col valid this cycle
// row        in   2           result row index
// col        in   2           result col index
// done       in   1           multiplier finished
// wr_data    out  DATA_WIDTH  signed load-port data
// wr_addr    out  4           load-port address, 0..M*P-1
// wr_wen     out  1           load-port write enable
// busy       out  1           high in COLLECT and FLUSH
// wb_done    out  1           1-cycle pulse after the last write
// sat_flag   out  1           sticky: some element saturated this capture
// dup_err    out  1           sticky: same (row,col) captured twice
// range_err  out  1           sticky: row>=M or col>=P seen
// incomplete_err out 1        sticky: done arrived with elements missing
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; capture mask cleared. Buffer contents are don't-care.
// - FSM: IDLE -arm-> COLLECT -done&full-> FLUSH -last write-> DONE -> IDLE.
//   COLLECT -done&!full-> IDLE, with incomplete_err set and no writes.
// - arm in IDLE: clears mask and all sticky flags, latches transpose, enters COLLECT.
//   arm outside IDLE is ignored.
// - COLLECT, on c_valid with row<M and col<P:
//   buf[row*P+col] <= sat(c_out>>>SHIFT); the mask bit is set.
//   If the mask bit is already set: overwrite and set dup_err.
//   Out-of-range index: no store; set range_err.
// - Rescale: arithmetic shift (floor toward -inf), then clamp to
//   [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Any clamp sets sat_flag.
// - c_valid and done in the same cycle: the element is stored first.
//   The full test then includes that element.
// - c_valid/done in IDLE, FLUSH or DONE: ignored.
// - FLUSH: exactly M*P consecutive cycles with wr_wen=1 and wr_addr=0..M*P-1 ascending.
//   transpose=0: wr_data=buf[wr_addr].
//   transpose=1: wr_data=buf[c*P+r] where wr_addr=r*P+c (requires M==P).
//   Outputs are registered, so the first write appears 1 cycle after entering FLUSH.
// - wb_done pulses the cycle after the final wr_wen. busy drops in that same cycle.
// - Latency: done (full) -> first wr_wen = 2 cycles; done -> wb_done = M*P+2 cycles.
// - rst mid-COLLECT or mid-FLUSH: wr_wen=0 from the next edge; state IDLE.
//   No further writes are issued. The downstream matrix is then partially written,
//   and the system must re-run.
// STRUCTURE
// - Shared include matrix_defs.vh: FSM state encodings (IDLE/COLLECT/FLUSH/DONE),
//   MAT_SIZE=M*P, load-port address width.
// - Sub-module fxp_shift_sat (combinational, params IN_W/OUT_W/SHIFT):
//   outputs the rescaled value plus a sat bit. Reusable by other fixed-point blocks.
// - Buffer is an M*P x DATA_WIDTH register array with an M*P-bit mask; no RAM inference.
// TESTING
// - Identity stream: C[r][0]={1024000,2048000,3072000}, others 0, then done
//   -> writes addr0=1000, addr3=2000, addr6=3000, others 0; wb_done at done+11.
// - c_out=-1 -> wr_data=-1; c_out=2^50 -> 2^31-1, sat_flag=1;
//   c_out=-(2^50) -> -2^31.
// - transpose=1, only C[0][1]=5120 nonzero -> addr3=5, addr1=0.
// - 8 elements then done -> incomplete_err=1, no wr_wen, back to IDLE;
//   duplicate (1,1) -> dup_err, last value written.
// - row=3 with c_valid -> range_err=1, buffer unchanged;
//   c_valid+done in the same cycle on the 9th element -> normal FLUSH.
// - rst asserted at the 4th FLUSH write -> wr_wen=0 next cycle, busy=0, no wb_done;
//   a re-arm then completes normally.

Source files
------------

// File: rtl/matrix_result_writeback_pkg.sv
// Shared definitions for the matrix result writeback block.
// - ADDR_W      : load-port address width (covers 0..M*P-1 for M,P <= 3)
// - wb_state_t  : writeback FSM states
// - lin_index() : row-major linear index of (r,c) in a matrix with 'cols' columns
package matrix_result_writeback_pkg;

    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } wb_state_t;

    function automatic logic [ADDR_W-1:0] lin_index(input logic [1:0] r,
                                                    input logic [1:0] c,
                                                    input int         cols);
        return ADDR_W'(int'(r) * cols + int'(c));
    endfunction

endpackage

// File: rtl/matrix_result_writeback_fxp_shift_sat.sv
// fxp_shift_sat: combinational fixed-point rescale.
// Arithmetic right shift by SHIFT (floor toward -inf), then clamp into the
// signed OUT_W range.
// Ports:
//   din  in  IN_W   signed input value
//   dout out OUT_W  rescaled, saturated value
//   sat  out 1      high when the clamp was applied
module fxp_shift_sat #(
    parameter int IN_W  = 66,
    parameter int OUT_W = 32,
    parameter int SHIFT = 10
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    logic signed [IN_W-1:0]     shifted;
    logic        [IN_W-OUT_W:0] upper;

    always_comb begin
        shifted = din >>> SHIFT;
        // The value fits iff every bit from the OUT_W sign position upward
        // is a copy of the sign bit.
        upper   = shifted[IN_W-1:OUT_W-1];
        sat     = !((&upper) || (~|upper));
        if (!sat)
            dout = shifted[OUT_W-1:0];
        else if (shifted[IN_W-1])
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        else
            dout = {1'b0, {(OUT_W-1){1'b1}}};
    end

endmodule

// File: rtl/matrix_result_writeback.sv
// matrix_result_writeback: captures an M x P multiplier result stream,
// rescales/saturates each element, then replays the buffer (optionally
// transposed) as M*P consecutive writes into a downstream load port.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   arm, transpose            start capture (IDLE only); transpose latched with arm
//   c_out, c_valid, row, col  result element stream
//   done                      multiplier finished
//   wr_data, wr_addr, wr_wen  load-port write (registered)
//   busy                      capture or flush in progress
//   wb_done                   1-cycle pulse after the last write
//   sat_flag, dup_err, range_err, incomplete_err   sticky status, cleared by arm
module matrix_result_writeback
    import matrix_result_writeback_pkg::*;
#(
    parameter int M          = 3,
    parameter int P          = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 66,
    parameter int SHIFT      = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic                         transpose,
    input  logic signed [ACC_WIDTH-1:0]  c_out,
    input  logic                         c_valid,
    input  logic        [1:0]            row,
    input  logic        [1:0]            col,
    input  logic                         done,
    output logic signed [DATA_WIDTH-1:0] wr_data,
    output logic        [ADDR_W-1:0]     wr_addr,
    output logic                         wr_wen,
    output logic                         busy,
    output logic                         wb_done,
    output logic                         sat_flag,
    output logic                         dup_err,
    output logic                         range_err,
    output logic                         incomplete_err
);

    localparam int MAT_SIZE = M * P;

    wb_state_t state, next_state;

    logic signed [DATA_WIDTH-1:0] data_buf [MAT_SIZE];
    logic        [MAT_SIZE-1:0]   mask;
    logic                         tp;
    logic        [ADDR_W-1:0]     flush_idx;
    logic        [1:0]            flush_r, flush_c;

    logic                         in_range, cap, full_now, last_flush;
    logic        [ADDR_W-1:0]     cap_idx, rd_idx;
    logic        [MAT_SIZE-1:0]   cap_bit;
    logic signed [DATA_WIDTH-1:0] scaled;
    logic                         scaled_sat;

    fxp_shift_sat #(
        .IN_W  (ACC_WIDTH),
        .OUT_W (DATA_WIDTH),
        .SHIFT (SHIFT)
    ) u_shift_sat (
        .din  (c_out),
        .dout (scaled),
        .sat  (scaled_sat)
    );

    // Capture-side decode. cap_bit folds the element arriving this cycle into
    // the full test, so c_valid and done together still count as complete.
    always_comb begin
        in_range   = (int'(row) < M) && (int'(col) < P);
        cap        = (state == ST_COLLECT) && c_valid && in_range;
        cap_idx    = lin_index(row, col, P);
        cap_bit    = cap ? (MAT_SIZE'(1) << cap_idx) : '0;
        full_now   = &(mask | cap_bit);
        last_flush = (flush_idx == ADDR_W'(MAT_SIZE - 1));
        // Transposed read: output (r,c) comes from stored (c,r).
        rd_idx     = tp ? lin_index(flush_c, flush_r, P) : flush_idx;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so every path assigns next_state; otherwise a latch is inferred.
        next_state = state;
        unique case (state)
            ST_IDLE:    if (arm) next_state = ST_COLLECT;
            ST_COLLECT: if (done) next_state = full_now ? ST_FLUSH : ST_IDLE;
            ST_FLUSH:   if (last_flush) next_state = ST_DONE;
            ST_DONE:    next_state = ST_IDLE;
        endcase
    end

    // Output logic: the final write is still on the port while the FSM sits
    // in DONE, so busy covers it through wr_wen.
    always_comb begin
        busy = (state == ST_COLLECT) || (state == ST_FLUSH) || wr_wen;
    end

    // NOTE: the element buffer has no reset; the mask alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (cap)
            data_buf[cap_idx] <= scaled;
    end

    // Control, status flags and registered load-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
            wr_data        <= '0;
            wr_addr        <= '0;
            wr_wen         <= 1'b0;
            wb_done        <= 1'b0;
            sat_flag       <= 1'b0;
            dup_err        <= 1'b0;
            range_err      <= 1'b0;
            incomplete_err <= 1'b0;
            mask           <= '0;
            tp             <= 1'b0;
            flush_idx      <= '0;
            flush_r        <= '0;
            flush_c        <= '0;
        end else begin
            wr_wen  <= 1'b0;
            wb_done <= (state == ST_DONE);
            unique case (state)
                ST_IDLE: begin
                    if (arm) begin
                        mask           <= '0;
                        sat_flag       <= 1'b0;
                        dup_err        <= 1'b0;
                        range_err      <= 1'b0;
                        incomplete_err <= 1'b0;
                        tp             <= transpose;
                        flush_idx      <= '0;
                        flush_r        <= '0;
                        flush_c        <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (cap) begin
                        mask <= mask | cap_bit;
                        if ((mask & cap_bit) != '0) dup_err <= 1'b1;
                        if (scaled_sat) sat_flag <= 1'b1;
                    end
                    if (c_valid && !in_range) range_err <= 1'b1;
                    if (done && !full_now) incomplete_err <= 1'b1;
                end
                ST_FLUSH: begin
                    wr_wen    <= 1'b1;
                    wr_addr   <= flush_idx;
                    wr_data   <= data_buf[rd_idx];
                    flush_idx <= flush_idx + 1'b1;
                    if (int'(flush_c) == P - 1) begin
                        flush_c <= '0;
                        flush_r <= flush_r + 1'b1;
                    end else begin
                        flush_c <= flush_c + 1'b1;
                    end
                end
                ST_DONE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_writeback.sv
// Self-checking bench for matrix_result_writeback: directed vectors plus
// randomized captures, scored against a plain-arithmetic reference model.
module tb_matrix_result_writeback;

    logic               clk = 1'b0;
    logic               rst, arm, transpose, c_valid, done;
    logic signed [65:0] c_out;
    logic        [1:0]  row, col;
    logic signed [31:0] wr_data;
    logic        [3:0]  wr_addr;
    logic               wr_wen, busy, wb_done, sat_flag, dup_err, range_err, incomplete_err;

    matrix_result_writeback dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .transpose      (transpose),
        .c_out          (c_out),
        .c_valid        (c_valid),
        .row            (row),
        .col            (col),
        .done           (done),
        .wr_data        (wr_data),
        .wr_addr        (wr_addr),
        .wr_wen         (wr_wen),
        .busy           (busy),
        .wb_done        (wb_done),
        .sat_flag       (sat_flag),
        .dup_err        (dup_err),
        .range_err      (range_err),
        .incomplete_err (incomplete_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]         r;
        logic [1:0]         c;
        logic signed [65:0] v;
    } elem_t;

    elem_t              stim[$];
    int                 got_addr[$];
    logic signed [31:0] got_data[$];
    int                 got_cyc[$];
    int                 wb_cyc_q[$];

    // Write-port monitor
    always @(negedge clk) begin
        if (wr_wen) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(wr_data);
            got_cyc.push_back(cyc);
        end
        if (wb_done) wb_cyc_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic signed [65:0] got,
                         input logic signed [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int r, input int c, input logic signed [65:0] v);
        elem_t e;
        e.r = 2'(r);
        e.c = 2'(c);
        e.v = v;
        stim.push_back(e);
    endtask

    task automatic clear_logs();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        wb_cyc_q.delete();
    endtask

    // Reference rescale: floor division by 2^10, then clamp to 32-bit signed.
    function automatic logic signed [65:0] model_scale(input logic signed [65:0] v,
                                                       output bit s);
        logic signed [65:0] q, hi, lo;
        q = v / 66'sd1024;
        if (v < 0 && (v % 66'sd1024) != 0) q = q - 1;
        hi = 66'sd2147483647;
        lo = -66'sd2147483648;
        s  = 1'b0;
        if (q > hi) begin q = hi; s = 1'b1; end
        if (q < lo) begin q = lo; s = 1'b1; end
        return q;
    endfunction

    function automatic logic signed [65:0] rand_val();
        logic [95:0]        raw;
        logic signed [65:0] v;
        raw = {$urandom, $urandom, $urandom};
        v   = raw[65:0];
        case ($urandom_range(0, 5))
            0: v = v >>> 50;
            1: v = v >>> $urandom_range(20, 34);
            2: v = v >>> $urandom_range(35, 45);
            3: case ($urandom_range(0, 3))
                   0: v = 66'sd2147483647 * 1024 + 1023;
                   1: v = 66'sd2147483648 * 1024;
                   2: v = -66'sd2147483648 * 1024;
                   default: v = -66'sd2147483648 * 1024 - 1;
               endcase
            default: ;
        endcase
        return v;
    endfunction

    // Drive the current stim queue as one capture and score the result.
    task automatic run_capture(input string nm, input bit tp, input bit dwl, input bit gaps);
        logic signed [65:0] eb[9];
        bit                 have[9];
        bit                 e_sat, e_dup, e_rng, full, s;
        int                 done_cyc, wait_n, idx, a, ra, ca;
        logic signed [65:0] expd;

        clear_logs();
        arm = 1'b1; transpose = tp;
        step();
        arm = 1'b0; transpose = ~tp;
        done_cyc = -1;
        foreach (stim[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                c_valid = 1'b0;
                step();
            end
            c_valid = 1'b1;
            row     = stim[i].r;
            col     = stim[i].c;
            c_out   = stim[i].v;
            done    = dwl && (i == stim.size() - 1);
            if (done) done_cyc = cyc;
            step();
        end
        c_valid = 1'b0;
        if (!dwl || stim.size() == 0) begin
            done     = 1'b1;
            done_cyc = cyc;
            step();
        end
        done  = 1'b0;
        c_out = rand_val();

        // Model of the capture
        e_sat = 0; e_dup = 0; e_rng = 0;
        foreach (have[k]) begin have[k] = 0; eb[k] = 0; end
        foreach (stim[i]) begin
            if (stim[i].r < 3 && stim[i].c < 3) begin
                idx = int'(stim[i].r) * 3 + int'(stim[i].c);
                if (have[idx]) e_dup = 1;
                have[idx] = 1;
                eb[idx]   = model_scale(stim[i].v, s);
                if (s) e_sat = 1;
            end else begin
                e_rng = 1;
            end
        end
        full = 1;
        foreach (have[k]) if (!have[k]) full = 0;

        if (full) begin
            wait_n = 0;
            while (wb_cyc_q.size() == 0 && wait_n < 40) begin
                step();
                wait_n++;
            end
            step();
        end else begin
            repeat (6) step();
        end

        check({nm, ".n_writes"}, got_addr.size(), full ? 9 : 0);
        check({nm, ".wb_done_cnt"}, wb_cyc_q.size(), full ? 1 : 0);
        for (int k = 0; k < got_addr.size(); k++) begin
            a  = k;
            ra = a / 3;
            ca = a % 3;
            expd = tp ? eb[ca * 3 + ra] : eb[a];
            check($sformatf("%s.addr%0d", nm, k), got_addr[k], k);
            check($sformatf("%s.data%0d", nm, k), got_data[k], expd);
        end
        if (got_cyc.size() > 0) check({nm, ".first_wr_lat"}, got_cyc[0] - done_cyc, 2);
        if (wb_cyc_q.size() > 0) check({nm, ".wb_done_lat"}, wb_cyc_q[0] - done_cyc, 11);
        check({nm, ".sat_flag"}, sat_flag, e_sat);
        check({nm, ".dup_err"}, dup_err, e_dup);
        check({nm, ".range_err"}, range_err, e_rng);
        check({nm, ".incomplete_err"}, incomplete_err, !full);
        check({nm, ".busy_end"}, busy, 0);
    endtask

    initial begin
        int perm[9];
        int j, t, cnt;
        bit tp_r;

        rst = 1'b1; arm = 0; transpose = 0; c_valid = 0; done = 0;
        c_out = '0; row = '0; col = '0;
        repeat (3) step();
        check("rst.wr_wen", wr_wen, 0);
        check("rst.wr_addr", wr_addr, 0);
        check("rst.wr_data", wr_data, 0);
        check("rst.busy", busy, 0);
        check("rst.wb_done", wb_done, 0);
        check("rst.flags", {sat_flag, dup_err, range_err, incomplete_err}, 0);
        rst = 1'b0;
        step();

        // Identity-style stream: only column 0 nonzero
        stim.delete();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                add(r, c, (c == 0) ? 66'sd1024000 * (r + 1) : 66'sd0);
        run_capture("ident", 0, 0, 0);
        if (got_data.size() == 9) begin
            check("ident.lit0", got_data[0], 1000);
            check("ident.lit3", got_data[3], 2000);
            check("ident.lit6", got_data[6], 3000);
            check("ident.lit4", got_data[4], 0);
        end

        // Rescale edge values
        stim.delete();
        add(0, 0, -66'sd1);
        add(0, 1, 66'sd1 <<< 50);
        add(0, 2, -(66'sd1 <<< 50));
        for (int k = 3; k < 9; k++) add(k / 3, k % 3, rand_val() >>> 40);
        run_capture("edge", 0, 0, 0);
        if (got_data.size() == 9) begin
            check("edge.neg1", got_data[0], -1);
            check("edge.pos_sat", got_data[1], 66'sd2147483647);
            check("edge.neg_sat", got_data[2], -66'sd2147483648);
        end
        check("edge.sat_lit", sat_flag, 1);

        // Transposed write
        stim.delete();
        for (int k = 0; k < 9; k++) add(k / 3, k % 3, (k == 1) ? 66'sd5120 : 66'sd0);
        run_capture("tpose", 1, 0, 0);
        if (got_data.size() == 9) begin
            check("tpose.addr3", got_data[3], 5);
            check("tpose.addr1", got_data[1], 0);
        end

        // Incomplete: 8 elements then done
        stim.delete();
        for (int k = 0; k < 8; k++) add(k / 3, k % 3, rand_val());
        run_capture("incomp", 0, 0, 0);

        // Duplicate (1,1), last value wins
        stim.delete();
        for (int k = 0; k < 9; k++) add(k / 3, k % 3, 66'sd1024 * (k + 1));
        add(1, 1, 66'sd1024 * 77);
        run_capture("dup", 0, 0, 0);
        if (got_data.size() == 9) check("dup.last_val", got_data[4], 77);

        // Out-of-range row, then 9th element together with done
        stim.delete();
        for (int k = 0; k < 4; k++) add(k / 3, k % 3, 66'sd1024 * (k + 10));
        add(3, 0, 66'sd1024 * 999);
        for (int k = 4; k < 9; k++) add(k / 3, k % 3, 66'sd1024 * (k + 10));
        run_capture("range", 0, 1, 0);

        // Randomized captures
        for (int run = 0; run < 8; run++) begin
            stim.delete();
            foreach (perm[k]) perm[k] = k;
            for (int k = 8; k > 0; k--) begin
                j = $urandom_range(0, k);
                t = perm[k]; perm[k] = perm[j]; perm[j] = t;
            end
            foreach (perm[k]) add(perm[k] / 3, perm[k] % 3, rand_val());
            if ($urandom_range(0, 2) == 0) add($urandom_range(0, 2), $urandom_range(0, 2), rand_val());
            if ($urandom_range(0, 2) == 0) add(3, $urandom_range(0, 3), rand_val());
            if ($urandom_range(0, 4) == 0) stim.delete($urandom_range(0, stim.size() - 1));
            tp_r = 1'($urandom_range(0, 1));
            run_capture($sformatf("rnd%0d", run), tp_r, 1'($urandom_range(0, 1)), 1);
        end

        // Reset during FLUSH at the 4th write
        clear_logs();
        arm = 1'b1; transpose = 0;
        step();
        arm = 1'b0;
        for (int k = 0; k < 9; k++) begin
            c_valid = 1'b1; row = 2'(k / 3); col = 2'(k % 3);
            c_out = 66'sd1024 * (k + 1);
            done = (k == 8);
            step();
        end
        c_valid = 0; done = 0;
        cnt = 0;
        for (int k = 0; k < 20 && cnt < 4; k++) begin
            step();
            if (wr_wen) cnt++;
        end
        check("rstflush.reached4", cnt, 4);
        rst = 1'b1;
        step();
        check("rstflush.wen", wr_wen, 0);
        check("rstflush.busy", busy, 0);
        rst = 1'b0;
        repeat (15) step();
        check("rstflush.n_writes", got_addr.size(), 4);
        check("rstflush.no_wb_done", wb_cyc_q.size(), 0);

        // Re-arm after the aborted flush
        stim.delete();
        for (int k = 0; k < 9; k++) add(k / 3, k % 3, rand_val());
        run_capture("rearm", 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
